vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator producing horizontal/vertical sync, display-enable and pixel coordinates from a single pixel-rate clock with clock-enable. It replaces the fixed horizontal-only sync counter in the display path and drives both the pixel source (x/y, de) and the VGA connector pins (hsync, vsync). Porch/sync lengths and sync polarities are set per video mode through parameters.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 77 +++++++
 tb/tb_vga_timing_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Video mode constants for the VGA raster timing generator.
// Also holds the shared helper that sums an axis into its total length.
package vga_timing_pkg;

    // 640x480@60, 25.175 MHz pixel clock, both syncs active-low
    localparam int VGA640_H_ACTIVE   = 640;
    localparam int VGA640_H_FP       = 16;
    localparam int VGA640_H_SYNC     = 96;
    localparam int VGA640_H_BP       = 48;
    localparam int VGA640_V_ACTIVE   = 480;
    localparam int VGA640_V_FP       = 10;
    localparam int VGA640_V_SYNC     = 2;
    localparam int VGA640_V_BP       = 33;
    localparam bit VGA640_H_SYNC_POL = 1'b0;
    localparam bit VGA640_V_SYNC_POL = 1'b0;

    // 800x600@60, 40 MHz pixel clock, both syncs active-high
    localparam int SVGA800_H_ACTIVE   = 800;
    localparam int SVGA800_H_FP       = 40;
    localparam int SVGA800_H_SYNC     = 128;
    localparam int SVGA800_H_BP       = 88;
    localparam int SVGA800_V_ACTIVE   = 600;
    localparam int SVGA800_V_FP       = 1;
    localparam int SVGA800_V_SYNC     = 4;
    localparam int SVGA800_V_BP       = 23;
    localparam bit SVGA800_H_SYNC_POL = 1'b1;
    localparam bit SVGA800_V_SYNC_POL = 1'b1;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with sync, active and last flags.
// Flags are computed from the next position so they stay aligned with pos.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA640_H_ACTIVE,
    parameter int FP     = VGA640_H_FP,
    parameter int SYNC   = VGA640_H_SYNC,
    parameter int BP     = VGA640_H_BP,
    parameter bit POL    = VGA640_H_SYNC_POL,
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] pos,
    output logic         sync,
    output logic         active,
    output logic         last
);

    localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] LAST_POS   = W'(TOTAL - 1);

    if (ACTIVE < 1 || SYNC < 1 || FP < 0 || BP < 0) begin : g_bad_params
        $error("vga_axis_counter: ACTIVE and SYNC must be non-zero, porches non-negative");
    end

    logic [W-1:0] pos_d, pos_q;
    logic         sync_d, sync_q;
    logic         active_d, active_q;
    logic         last_d, last_q;

    // Next position and the flags describing that next position
    always_comb begin
        pos_d = pos_q;
        if (reset) begin
            pos_d = '0;
        end else if (step) begin
            pos_d = last_q ? '0 : pos_q + W'(1);
        end else begin
            pos_d = pos_q;
        end
        sync_d   = ((pos_d >= SYNC_FIRST) && (pos_d <= SYNC_LAST)) ? POL : !POL;
        active_d = (pos_d < ACTIVE_END);
        last_d   = (pos_d == LAST_POS);
    end

    // Position and flag registers
    always_ff @(posedge clk) begin
        pos_q    <= pos_d;
        sync_q   <= sync_d;
        active_q <= active_d;
        last_q   <= last_d;
    end

    assign pos    = pos_q;
    assign sync   = sync_q;
    assign active = active_q;
    assign last   = last_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y coordinates, hsync/vsync, display enable
// and line/frame end markers from a pixel clock qualified by ce.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter bit H_SYNC_POL = VGA640_H_SYNC_POL,
    parameter bit V_SYNC_POL = VGA640_V_SYNC_POL,
    localparam int H_TOTAL   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_end,
    output logic          frame_end
);

    logic h_active, h_last;
    logic v_active, v_last;
    logic v_step;

    // The vertical axis advances on the ce edge that wraps x
    assign v_step = ce && h_last;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_SYNC_POL)
    ) u_h (
        .clk    (clk),
        .reset  (reset),
        .step   (ce),
        .pos    (x),
        .sync   (hsync),
        .active (h_active),
        .last   (h_last)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_SYNC_POL)
    ) u_v (
        .clk    (clk),
        .reset  (reset),
        .step   (v_step),
        .pos    (y),
        .sync   (vsync),
        .active (v_active),
        .last   (v_last)
    );

    // Both operands are flop outputs of the same position, so no skew to x/y
    assign de        = h_active && v_active;
    assign line_end  = h_last;
    assign frame_end = h_last && v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a small 8x6 mode and the default 640x480 mode share
// reset/ce; both are compared against a count-of-ce-edges raster model.
module tb_vga_timing_gen;

    localparam int SHA = 4, SHF = 1, SHS = 2, SHB = 1;
    localparam int SVA = 3, SVF = 1, SVS = 1, SVB = 1;
    localparam int DHA = 640, DHF = 16, DHS = 96, DHB = 48;
    localparam int DVA = 480, DVF = 10, DVS = 2, DVB = 33;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;

    logic       hsync_s, vsync_s, de_s, line_end_s, frame_end_s;
    logic [2:0] x_s, y_s;
    logic       hsync_d, vsync_d, de_d, line_end_d, frame_end_d;
    logic [9:0] x_d, y_d;

    logic [10:0] obs_s;
    logic [24:0] obs_d;
    assign obs_s = {x_s, y_s, hsync_s, vsync_s, de_s, line_end_s, frame_end_s};
    assign obs_d = {x_d, y_d, hsync_d, vsync_d, de_d, line_end_d, frame_end_d};

    int checks = 0;
    int failures = 0;
    int n = 0;  // ce edges since the last reset

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) dut_s (
        .clk(clk), .reset(reset), .ce(ce),
        .hsync(hsync_s), .vsync(vsync_s), .de(de_s),
        .x(x_s), .y(y_s), .line_end(line_end_s), .frame_end(frame_end_s)
    );

    vga_timing_gen dut_d (
        .clk(clk), .reset(reset), .ce(ce),
        .hsync(hsync_d), .vsync(vsync_d), .de(de_d),
        .x(x_d), .y(y_d), .line_end(line_end_d), .frame_end(frame_end_d)
    );

    // Raster rules applied to the n-th position of a free-running scan
    function automatic logic [4:0] model_flags(input int pn, input int ha, input int hf,
            input int hs, input int hb, input int va, input int vf, input int vs, input int vb);
        int ht, vt, px, py;
        logic hsa, vsa;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        px  = pn % ht;
        py  = (pn / ht) % vt;
        hsa = (px >= ha + hf) && (px < ha + hf + hs);
        vsa = (py >= va + vf) && (py < va + vf + vs);
        return {!hsa, !vsa, (px < ha) && (py < va), px == ht - 1, (px == ht - 1) && (py == vt - 1)};
    endfunction

    function automatic logic [10:0] exp_s(input int pn);
        int px, py;
        px = pn % 8;
        py = (pn / 8) % 6;
        return {3'(px), 3'(py), model_flags(pn, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB)};
    endfunction

    function automatic logic [24:0] exp_d(input int pn);
        int px, py;
        px = pn % 800;
        py = (pn / 800) % 525;
        return {10'(px), 10'(py), model_flags(pn, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB)};
    endfunction

    task automatic tick(input logic r, input logic c);
        @(negedge clk);
        reset = r;
        ce    = c;
        @(posedge clk);
        #1;
        if (r) n = 0;
        else if (c) n = n + 1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        checks++;
        if (obs_s !== {3'd0, 3'd0, 5'b11100}) begin
            failures++;
            $display("FAIL reset_small got=%h exp=%h", obs_s, {3'd0, 3'd0, 5'b11100});
        end
        checks++;
        if (obs_d !== {10'd0, 10'd0, 5'b11100}) begin
            failures++;
            $display("FAIL reset_default got=%h exp=%h", obs_d, {10'd0, 10'd0, 5'b11100});
        end
        tick(1'b0, 1'b1);
        checks++;
        if ({x_s, y_s} !== {3'd1, 3'd0}) begin
            failures++;
            $display("FAIL first_step got x=%0d y=%0d exp x=1 y=0", x_s, y_s);
        end
    endtask

    task automatic test_line();
        logic [7:0] hs_mask, de_mask;
        int exp_x;
        hs_mask = 8'h00;
        de_mask = 8'h00;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1);
            exp_x = (i + 1) % 8;
            checks++;
            if (32'(x_s) !== 32'(exp_x)) begin
                failures++;
                $display("FAIL line_x step=%0d got=%0d exp=%0d", i, x_s, exp_x);
            end
            checks++;
            if (obs_s !== exp_s(n)) begin
                failures++;
                $display("FAIL line_outputs n=%0d got=%h exp=%h", n, obs_s, exp_s(n));
            end
            if (hsync_s === 1'b0) hs_mask[x_s] = 1'b1;
            if (de_s === 1'b1) de_mask[x_s] = 1'b1;
        end
        checks++;
        if (hs_mask !== 8'b0110_0000) begin
            failures++;
            $display("FAIL hsync_window got=%b exp=%b", hs_mask, 8'b0110_0000);
        end
        checks++;
        if (de_mask !== 8'b0000_1111) begin
            failures++;
            $display("FAIL de_window got=%b exp=%b", de_mask, 8'b0000_1111);
        end
    endtask

    task automatic test_frame();
        int fe_cnt;
        logic [5:0] fe_pos;
        fe_cnt = 0;
        fe_pos = 6'h00;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 48; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs_s !== exp_s(n)) begin
                failures++;
                $display("FAIL frame_outputs n=%0d got=%h exp=%h", n, obs_s, exp_s(n));
            end
            if (frame_end_s === 1'b1) begin
                fe_cnt++;
                fe_pos = {x_s, y_s};
            end
        end
        checks++;
        if (fe_cnt != 1 || fe_pos !== {3'd7, 3'd5}) begin
            failures++;
            $display("FAIL frame_end got count=%0d pos=%h exp count=1 pos=%h", fe_cnt, fe_pos, {3'd7, 3'd5});
        end
        checks++;
        if ({x_s, y_s, de_s} !== {3'd0, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL frame_wrap got x=%0d y=%0d de=%b exp x=0 y=0 de=1", x_s, y_s, de_s);
        end
    endtask

    task automatic test_vsync();
        int vs_cnt, vs_bad;
        logic prev_vs;
        logic [5:0] fall_pos, rise_pos;
        vs_cnt = 0;
        vs_bad = 0;
        fall_pos = 6'h3f;
        rise_pos = 6'h3f;
        tick(1'b1, 1'b0);
        prev_vs = vsync_s;
        for (int i = 0; i < 48; i++) begin
            tick(1'b0, 1'b1);
            if (vsync_s === 1'b0) begin
                vs_cnt++;
                if (y_s !== 3'd4) vs_bad++;
            end
            if (prev_vs === 1'b1 && vsync_s === 1'b0) fall_pos = {x_s, y_s};
            if (prev_vs === 1'b0 && vsync_s === 1'b1) rise_pos = {x_s, y_s};
            prev_vs = vsync_s;
        end
        checks++;
        if (vs_cnt != 8 || vs_bad != 0) begin
            failures++;
            $display("FAIL vsync_lines got low=%0d off_line=%0d exp low=8 off_line=0", vs_cnt, vs_bad);
        end
        checks++;
        if (fall_pos !== {3'd0, 3'd4} || rise_pos !== {3'd0, 3'd5}) begin
            failures++;
            $display("FAIL vsync_edges got fall=%h rise=%h exp fall=%h rise=%h",
                     fall_pos, rise_pos, {3'd0, 3'd4}, {3'd0, 3'd5});
        end
    endtask

    task automatic test_ce_gate();
        int hi, period;
        logic c;
        hi = 0;
        period = -1;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            c = ((i % 4) == 0) || ((i % 4) == 3);
            tick(1'b0, c);
            checks++;
            if (obs_s !== exp_s(n) || obs_d !== exp_d(n)) begin
                failures++;
                $display("FAIL ce_hold i=%0d ce=%b got=%h/%h exp=%h/%h", i, c, obs_s, obs_d, exp_s(n), exp_d(n));
            end
            if (c) hi++;
            if (c && x_s === 3'd0 && period < 0) period = hi;
        end
        checks++;
        if (period != 8) begin
            failures++;
            $display("FAIL line_period got=%0d exp=8", period);
        end
    endtask

    task automatic test_random();
        logic r, c;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            c = 1'($urandom_range(0, 1));
            tick(r, c);
            checks++;
            if (obs_s !== exp_s(n) || obs_d !== exp_d(n)) begin
                failures++;
                $display("FAIL random i=%0d r=%b ce=%b got=%h/%h exp=%h/%h", i, r, c, obs_s, obs_d, exp_s(n), exp_d(n));
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 38; i++) tick(1'b0, 1'b1);
        checks++;
        if ({x_s, y_s} !== {3'd6, 3'd4} || obs_s !== exp_s(n)) begin
            failures++;
            $display("FAIL reach_6_4 got=%h exp=%h", obs_s, exp_s(38));
        end
        tick(1'b1, 1'($urandom_range(0, 1)));
        checks++;
        if (obs_s !== {3'd0, 3'd0, 5'b11100}) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", obs_s, {3'd0, 3'd0, 5'b11100});
        end
    endtask

    task automatic test_default();
        int hs_low, de_hi, lines, first_hs;
        hs_low = 0;
        de_hi = 0;
        lines = 0;
        first_hs = -1;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 8000; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs_d !== exp_d(n) || obs_s !== exp_s(n)) begin
                failures++;
                $display("FAIL default_outputs n=%0d got=%h exp=%h", n, obs_d, exp_d(n));
            end
            if (hsync_d === 1'b0) begin
                hs_low++;
                if (first_hs < 0) first_hs = int'(x_d);
            end
            if (de_d === 1'b1) de_hi++;
            if (line_end_d === 1'b1) lines++;
        end
        checks++;
        if (hs_low != 960 || lines != 10 || first_hs != 656) begin
            failures++;
            $display("FAIL default_hsync got low=%0d lines=%0d first=%0d exp low=960 lines=10 first=656",
                     hs_low, lines, first_hs);
        end
        checks++;
        if (de_hi != 6400) begin
            failures++;
            $display("FAIL default_de got=%0d exp=6400", de_hi);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_vsync();
        test_ce_gate();
        test_random();
        test_reset_mid();
        test_default();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
